monster_controller: RTL

Game-logic stage directly upstream of the VGA block controller: decides which lane monsters (top, bottom, left, right) are present, times their attacks, and tracks lives and score. Runs on the same slow game clock as the display controller. Consumes laser-kill pulses and shield status, and drives the monster-present and lane-broken signals that the renderer draws.

---
 rtl/monster_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/monster_controller.sv
// Purpose: lane-monster game logic (spawn, attack timing, lives, score) ahead of the VGA renderer.
// Latency: every output is registered; an input sampled at edge n is visible right after edge n.
// Backpressure: none; hit is a one-cycle pulse, and shield and Start are levels sampled each cycle.
//
// Ports:
//   Clk, Reset      slow game clock; asynchronous active-high reset
//   Start           level: IDLE->PLAY when high, OVER->IDLE when low
//   hit[3:0]        kill pulses per lane ([0]=top [1]=bottom [2]=left [3]=right)
//   shield[3:0]     shield raised per lane
//   monster[3:0]    monster present per lane
//   broken[3:0]     one-cycle pulse for an unshielded attack
//   lives[1:0]      remaining lives
//   score[9:0]      kill count, saturating at 1023
//   game_over       high while in OVER
module monster_controller #(
    parameter int          SPAWN_MIN       = 20,
    parameter int          SPAWN_RAND_BITS = 6,
    parameter int          ATTACK_TICKS    = 150,
    parameter int          LIVES           = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] hit,
    input  logic [3:0] shield,
    output logic [3:0] monster,
    output logic [3:0] broken,
    output logic [1:0] lives,
    output logic [9:0] score,
    output logic       game_over
);

    // The spawn counter must hold SPAWN_MIN plus the largest random offset.
    localparam int CNT_W = $clog2(SPAWN_MIN + (1 << SPAWN_RAND_BITS)) + 1;
    localparam int TMR_W = $clog2(ATTACK_TICKS + 1);

    localparam logic [CNT_W-1:0] SPAWN_BASE  = CNT_W'(SPAWN_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [TMR_W-1:0] ATTACK_LOAD = TMR_W'(ATTACK_TICKS);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [1:0]       LIVES_INIT  = 2'(LIVES);
    localparam logic [15:0]      LFSR_MASK   = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [15:0]             lfsr, lfsr_nxt;
    logic [CNT_W-1:0]        spawn_cnt, cnt_nxt;
    logic [3:0][TMR_W-1:0]   timer, timer_nxt;
    logic [3:0]              monster_nxt, broken_nxt;
    logic [1:0]              lives_nxt;
    logic [9:0]              score_nxt;

    logic [3:0]              valid_hit;
    logic [3:0]              expired;
    logic [3:0]              attack;
    logic [3:0]              unshielded;
    logic [2:0]              kills;
    logic [2:0]              losses;
    logic [10:0]             score_sum;
    logic [1:0]              spawn_lane;
    logic [SPAWN_RAND_BITS-1:0] spawn_rand;
    logic [CNT_W-1:0]        spawn_reload;
    logic                    spawn_due;
    logic [3:0]              spawn_onehot;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Lane events, all judged on the registered (pre-edge) state.
    always_comb begin
        expired = '0;
        for (int i = 0; i < 4; i++) begin
            expired[i] = monster[i] && (timer[i] == '0);
        end
    end

    assign valid_hit    = hit & monster;
    assign attack       = expired & ~hit;          // a hit on the expiring lane wins
    assign unshielded   = attack & ~shield;
    assign kills        = popcnt4(valid_hit);
    assign losses       = popcnt4(unshielded);
    assign score_sum    = {1'b0, score} + {8'b0, kills};

    assign spawn_lane   = lfsr[1:0];
    assign spawn_rand   = lfsr[SPAWN_RAND_BITS+1:2];
    assign spawn_reload = SPAWN_BASE + CNT_W'(spawn_rand);
    assign spawn_due    = (spawn_cnt == '0);
    // An occupied lane (including one being hit or attacking this cycle) skips the spawn.
    assign spawn_onehot = (spawn_due && !monster[spawn_lane]) ? (4'b0001 << spawn_lane) : 4'b0000;

    // Galois LFSR runs in every state so spawn lanes depend on how long the player idled.
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = spawn_cnt;
        timer_nxt   = timer;
        monster_nxt = monster;
        broken_nxt  = '0;
        lives_nxt   = lives;
        score_nxt   = score;

        case (state)
            ST_IDLE: begin
                monster_nxt = '0;
                timer_nxt   = '0;
                cnt_nxt     = '0;
                lives_nxt   = LIVES_INIT;
                score_nxt   = '0;
                if (Start) begin
                    state_nxt = ST_PLAY;
                    cnt_nxt   = SPAWN_BASE;
                end
            end

            ST_PLAY: begin
                if (lives == 2'd0) begin
                    // Last life went at the previous edge: freeze score, clear the field.
                    state_nxt   = ST_OVER;
                    monster_nxt = '0;
                    timer_nxt   = '0;
                    cnt_nxt     = '0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (valid_hit[i]) begin
                            timer_nxt[i] = '0;
                        end else if (monster[i] && (timer[i] != '0)) begin
                            timer_nxt[i] = timer[i] - TMR_ONE;
                        end
                        if (spawn_onehot[i]) begin
                            timer_nxt[i] = ATTACK_LOAD;
                        end
                    end
                    monster_nxt = (monster & ~valid_hit & ~attack) | spawn_onehot;
                    broken_nxt  = unshielded;
                    score_nxt   = score_sum[10] ? 10'h3FF : score_sum[9:0];
                    lives_nxt   = ({1'b0, lives} <= losses) ? 2'd0 : (lives - losses[1:0]);
                    cnt_nxt     = spawn_due ? spawn_reload : (spawn_cnt - CNT_ONE);
                end
            end

            ST_OVER: begin
                monster_nxt = '0;
                timer_nxt   = '0;
                cnt_nxt     = '0;
                if (!Start) begin
                    state_nxt = ST_IDLE;
                    lives_nxt = LIVES_INIT;
                    score_nxt = '0;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                monster_nxt = '0;
                timer_nxt   = '0;
                cnt_nxt     = '0;
                lives_nxt   = LIVES_INIT;
                score_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            spawn_cnt <= '0;
            timer     <= '0;
            monster   <= '0;
            broken    <= '0;
            lives     <= LIVES_INIT;
            score     <= '0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            spawn_cnt <= cnt_nxt;
            timer     <= timer_nxt;
            monster   <= monster_nxt;
            broken    <= broken_nxt;
            lives     <= lives_nxt;
            score     <= score_nxt;
        end
    end

    assign game_over = (state == ST_OVER);

endmodule
